// File: rtl/sda_drv_if.sv
// SDA driver bus bundle: SCL sample, transmit bit and mode select in, SDA drive level and busy out.
// master drives the requests; slave is the sda_drv side.
interface sda_drv_if;
  logic       scl_in;
  logic       tx_out;
  logic [1:0] sda_mode;
  logic       sda_out;
  logic       busy;

  modport master (output scl_in, output tx_out, output sda_mode,
                  input  sda_out, input busy);
  modport slave  (input  scl_in, input  tx_out, input  sda_mode,
                  output sda_out, output busy);
endinterface

// File: rtl/sda_drv.sv
// SDA output driver: start/stop/idle levels change at once; transmit data changes wait for SCL low hold time.
// Optional feature: define SDA_SCL_SYNC_EN to pass scl_in through a 2-flop synchroniser.
//
// state | meaning
// IDLE  | sda_out matches target, or a non-transmit change was just applied
// WAIT  | transmit-data change pending until SCL has been low for HOLD_CYCLES
module sda_drv #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst,
  sda_drv_if.slave bus
);
  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic          sda_q, sda_nxt;
  logic          busy_q;
  logic [CW-1:0] hold_cnt;
  logic          scl_s;
  logic          hold_ok;
  logic          target;
  logic          tx_mode;

`ifdef SDA_SCL_SYNC_EN
  logic scl_m, scl_ss;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_m  <= 1'b1;
      scl_ss <= 1'b1;
    end else begin
      scl_m  <= bus.scl_in;
      scl_ss <= scl_m;
    end
  end

  assign scl_s = scl_ss;
`else
  assign scl_s = bus.scl_in;
`endif

  always_ff @(posedge clk) begin
    if (rst || scl_s)
      hold_cnt <= '0;
    else if (hold_cnt != HOLD_MAX)
      hold_cnt <= hold_cnt + CW'(1);
  end

  assign hold_ok = !scl_s && (hold_cnt == HOLD_MAX);
  assign tx_mode = (bus.sda_mode == 2'b11);

  always_comb begin
    target = 1'b1;
    case (bus.sda_mode)
      2'b00:   target = 1'b1;
      2'b01:   target = 1'b0;
      2'b10:   target = 1'b1;
      default: target = bus.tx_out;
    endcase
  end

  always_comb begin
    state_nxt = state;
    sda_nxt   = sda_q;
    case (state)
      IDLE: begin
        if (target != sda_q) begin
          if (!tx_mode || hold_ok)
            sda_nxt = target;
          else
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!tx_mode) begin
          sda_nxt   = target;
          state_nxt = IDLE;
        end else if (target == sda_q) begin
          state_nxt = IDLE;
        end else if (hold_ok) begin
          sda_nxt   = target;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sda_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sda_q  <= sda_nxt;
      busy_q <= (state_nxt == WAIT);
    end
  end

  assign bus.sda_out = sda_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sda_drv.sv
// Scoreboard bench for sda_drv: stimulus queues expected {sda_out, busy}; a monitor checks after each edge.
// Expected SCL-fall latencies follow SDA_SCL_SYNC_EN when it is defined for the build.
module tb_sda_drv;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sda_drv_if ba ();
  sda_drv_if bz ();

  sda_drv #(.HOLD_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  sda_drv #(.HOLD_CYCLES(0)) dut_z (.clk(clk), .rst(rst), .bus(bz.slave));

`ifdef SDA_SCL_SYNC_EN
  localparam int LAT  = 7;
  localparam int LAT0 = 3;
`else
  localparam int LAT  = 5;
  localparam int LAT0 = 1;
`endif

  typedef struct {
    bit    dut;
    logic  sda;
    logic  busy;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) begin
    exp_t e;
    logic a_sda, a_busy;
    #1;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      a_sda  = e.dut ? bz.sda_out : ba.sda_out;
      a_busy = e.dut ? bz.busy    : ba.busy;
      n_cmp++;
      if (a_sda !== e.sda || a_busy !== e.busy) begin
        n_err++;
        $display("FAIL %s: sda_out/busy got %b/%b want %b/%b", e.name, a_sda, a_busy, e.sda, e.busy);
      end
    end
  end

  // Queue the value expected after the coming edge, then advance to the next falling edge.
  task automatic cyc(input bit dut, input logic s, input logic b, input string nm);
    exp_t e;
    e.dut = dut; e.sda = s; e.busy = b; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic [1:0] m, input logic tx, input logic scl);
    ba.sda_mode = m; ba.tx_out = tx; ba.scl_in = scl;
  endtask

  initial begin
    set_a(2'b00, 1'b1, 1'b1);
    bz.sda_mode = 2'b00; bz.tx_out = 1'b1; bz.scl_in = 1'b1;
    @(negedge clk);

    rst = 1'b1;
    cyc(0, 1'b1, 1'b0, "reset0");
    cyc(0, 1'b1, 1'b0, "reset1");
    cyc(1, 1'b1, 1'b0, "reset_z");
    rst = 1'b0;

    set_a(2'b01, 1'b1, 1'b1); cyc(0, 1'b0, 1'b0, "mode_start");
    set_a(2'b10, 1'b1, 1'b1); cyc(0, 1'b1, 1'b0, "mode_stop");
    set_a(2'b00, 1'b1, 1'b1); cyc(0, 1'b1, 1'b0, "mode_idle");

    set_a(2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b1, "wait_scl_high");
    ba.scl_in = 1'b0;
    for (int i = 1; i < LAT; i++) cyc(0, 1'b1, 1'b1, "wait_hold");
    cyc(0, 1'b0, 1'b0, "hold_release");
    cyc(0, 1'b0, 1'b0, "after_release");
    ba.scl_in = 1'b1;
    cyc(0, 1'b0, 1'b0, "tx_steady_scl_high");

    set_a(2'b00, 1'b1, 1'b1); cyc(0, 1'b1, 1'b0, "back_idle");
    set_a(2'b11, 1'b0, 1'b1); cyc(0, 1'b1, 1'b1, "pend_revert");
    ba.scl_in = 1'b0;
    cyc(0, 1'b1, 1'b1, "pend_low1");
    cyc(0, 1'b1, 1'b1, "pend_low2");
    ba.tx_out = 1'b1;
    cyc(0, 1'b1, 1'b0, "tx_reverted");
    cyc(0, 1'b1, 1'b0, "tx_reverted_hold");

    set_a(2'b11, 1'b0, 1'b1); cyc(0, 1'b1, 1'b1, "pend_mode_sw");
    ba.sda_mode = 2'b01;      cyc(0, 1'b0, 1'b0, "wait_to_start");
    set_a(2'b00, 1'b1, 1'b1); cyc(0, 1'b1, 1'b0, "idle_again");
    set_a(2'b11, 1'b0, 1'b1); cyc(0, 1'b1, 1'b1, "pend_rst");
    rst = 1'b1;               cyc(0, 1'b1, 1'b0, "rst_in_wait");
    rst = 1'b0;
    set_a(2'b00, 1'b1, 1'b1); cyc(0, 1'b1, 1'b0, "post_rst");

    ba.scl_in = 1'b0;
    for (int i = 0; i < LAT; i++) cyc(0, 1'b1, 1'b0, "idle_scl_low");
    set_a(2'b11, 1'b0, 1'b0); cyc(0, 1'b0, 1'b0, "immediate_tx0");
    ba.tx_out = 1'b1;         cyc(0, 1'b1, 1'b0, "immediate_tx1");

    bz.sda_mode = 2'b11; bz.tx_out = 1'b0; bz.scl_in = 1'b1;
    cyc(1, 1'b1, 1'b1, "z_wait");
    cyc(1, 1'b1, 1'b1, "z_wait2");
    bz.scl_in = 1'b0;
    for (int i = 1; i < LAT0; i++) cyc(1, 1'b1, 1'b1, "z_sync_delay");
    cyc(1, 1'b0, 1'b0, "z_release");

    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sda_drv.md
SDA_DRV -- requirements
Module: sda_drv

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of clk cycles SCL must be seen low before a transmit-data change may drive SDA (legal range 0..255).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: scl_in  input  1  bus SCL level as seen by the controller.
REQ-005 Port: tx_out  input  1  serial transmit data bit.
REQ-006 Port: sda_mode  input  2  output select (00 idle, 01 start, 10 stop, 11 transmit).
REQ-007 Port: sda_out  output  1  registered SDA drive level.
REQ-008 Port: busy  output  1  registered; high while a transmit-mode change waits for hold time.

Function
REQ-009 Target level SHALL be: mode 00 -> 1, mode 01 -> 0, mode 10 -> 1, mode 11 -> tx_out.
REQ-010 scl_s (the internal SCL sample) SHALL be scl_in after the optional synchroniser (see Configuration).
REQ-011 hold_cnt (width clog2(HOLD_CYCLES+1), minimum 1) SHALL clear to 0 on any cycle scl_s=1 and increment, saturating at HOLD_CYCLES, on every cycle scl_s=0.
REQ-012 hold_ok SHALL be defined as scl_s=0 AND hold_cnt=HOLD_CYCLES; HOLD_CYCLES=0 makes hold_ok equal to scl_s=0.
REQ-013 FSM SHALL have two states, IDLE and WAIT; busy=1 exactly when the state is WAIT.
REQ-014 IDLE, target=sda_out: no change.
REQ-015 IDLE, target differs, mode is not 11: sda_out SHALL take target at the next rising edge (1-cycle latency), regardless of SCL, and the FSM stays in IDLE.
REQ-016 IDLE, target differs, mode 11: if hold_ok, sda_out SHALL take target at the next edge and the FSM stays in IDLE; otherwise the FSM SHALL go to WAIT and sda_out is held.
REQ-017 WAIT, mode 11, hold_ok: sda_out SHALL take target and the FSM SHALL return to IDLE.
REQ-018 WAIT, mode 11, target equals sda_out (tx_out reverted): the FSM SHALL return to IDLE with no change to sda_out.
REQ-019 WAIT, mode not 11: the REQ-015 rules SHALL apply (immediate update) and the FSM SHALL return to IDLE.
REQ-020 In mode 11, sda_out SHALL never change on a cycle where scl_s=1.
REQ-021 tx_out SHALL be sampled on the cycle the update is applied, not the cycle the request began.

Reset
REQ-022 When rst=1 at a rising edge: state IDLE, sda_out=1, busy=0, hold_cnt=0, synchroniser flops=1; this takes priority over all other activity, including a pending WAIT.
REQ-023 On the first edge after rst deasserts, behaviour SHALL follow the Function rules with these reset values.

Configuration
REQ-024 Macro SDA_SCL_SYNC_EN.
- Defined: scl_in SHALL pass through a 2-flop synchroniser before use as scl_s, adding 2 cycles of SCL latency to hold_cnt and hold_ok.
- Undefined: scl_s SHALL equal scl_in directly, with no added latency.
- All other behaviour SHALL be identical in both builds.

Verification
All scenarios use HOLD_CYCLES=4 and SDA_SCL_SYNC_EN undefined unless stated.
REQ-025 Reset, then modes 00/01/10 in turn with scl_in=1 -> sda_out=1, 0, 1, each one cycle after the mode is applied; busy stays 0 throughout.
REQ-026 Mode 11, sda_out=1, scl_in=1, tx_out=0 -> sda_out stays 1 and busy=1 for as long as SCL is high.
- Then drop scl_in to 0: sda_out goes to 0 on the 5th edge after the drop, and busy falls on that same edge.
REQ-027 Mode 11, pending change as in REQ-026 with scl_in=0 for 2 cycles, then tx_out returns to 1 -> busy clears next edge and sda_out stays 1.
REQ-028 Pending WAIT, then switch to mode 01 -> sda_out=0 on the next edge, busy=0.
- Separately, assert rst during WAIT -> sda_out=1 and busy=0 next edge.
REQ-029 SDA_SCL_SYNC_EN defined, repeat REQ-026 -> sda_out changes on the 7th edge after scl_in falls.
- With HOLD_CYCLES=0 and the macro undefined -> change on the 1st edge after the fall.
